ysyx_25030085_ifu: RTL and testbench
====================================

# ysyx_25030085_ifu

Instruction fetch unit for the multi-cycle NPC core. Consumes the architectural PC driven by the PC register and issues one AXI4-Lite-style read per instruction to instruction memory. Holds the returned word until the decode/execute stage accepts it. Signals the PC register, via `pc_advance`, when the PC may step to its next value.

## Interface
Parameters:
- `NOP_INST`, default `32'h0000_0013`: word presented on any fetch error.
- `TIMEOUT`, default `255`: maximum cycles spent in WAIT before a fetch error is declared; width of the counter is 8 bits.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pc` in 32: current PC from the PC register; sampled on IDLE→REQ.
- `fetch_en` in 1: permission to start a new fetch.
- `flush` in 1: discard the current fetch (redirect from trap or branch).
- `araddr` out 32: read address.
- `arvalid` out 1: read request valid.
- `arready` in 1: memory accepts the request.
- `rdata` in 32: read data.
- `rresp` in 2: response code; nonzero means error.
- `rvalid` in 1: read data valid.
- `rready` out 1: IFU accepts read data.
- `inst` out 32: fetched instruction.
- `inst_pc` out 32: PC of `inst`.
- `inst_valid` out 1: `inst` is valid for downstream.
- `inst_ready` in 1: downstream accepts `inst`.
- `fetch_err` out 1: qualifies `inst`; set on misalignment, nonzero `rresp`, or timeout.
- `pc_advance` out 1: one-cycle pulse; equals `inst_valid & inst_ready`.

## Operation
The FSM has four states, and every output is decoded from state or registers.

- **IDLE**
  - If `fetch_en` is high, latch `pc` into `araddr` and `inst_pc`.
  - If `pc[1:0]==0`, go to REQ.
  - Otherwise load `inst=NOP_INST`, `fetch_err=1`, and go to HOLD with no bus request.
- **REQ**
  - `arvalid=1`. It stays high, with `araddr` held stable, until `arready`. The request is never withdrawn, including under `flush`.
  - On `arready`, go to WAIT and clear the timeout counter.
- **WAIT**
  - `rready=1`.
  - On `rvalid`, register `inst=rdata` and `fetch_err=(rresp!=0)`, then go to HOLD.
  - Otherwise the counter increments. When it reaches `TIMEOUT`, load `inst=NOP_INST`, `fetch_err=1`, and go to HOLD. A late `rvalid` is then absorbed by the drop flag.
- **HOLD**
  - `inst_valid=1`, and `inst`, `inst_pc` and `fetch_err` are stable.
  - On `inst_ready`, pulse `pc_advance` and go to IDLE.

Drop flag:
- A `flush` in REQ or WAIT sets the drop flag; a WAIT timeout also sets it.
- While the flag is set, the beat still completes on the bus. The response is discarded (`rready=1` until `rvalid`), then the FSM goes to IDLE with no HOLD.

`flush` in HOLD:
- Go to IDLE.
- Force `inst_valid=0` in that same cycle by gating it with `!flush`, so no `pc_advance` is issued.
- `flush` takes priority over a simultaneous `inst_ready`.

`flush` in IDLE has no effect.

Reset:
- From any state, including mid-transaction, reset enters IDLE on the next edge.
- `arvalid`, `rready`, `inst_valid`, `fetch_err` and `pc_advance` are 0; `inst`, `inst_pc`, `araddr` and the counter are 0; the drop flag is cleared.
- The memory model is reset together with the IFU.

## Timing
- Zero-wait memory (`arready=1` in REQ, `rvalid` the cycle after acceptance): `fetch_en` sampled at edge 0 → REQ in cycle 1 → WAIT in cycle 2 → `inst_valid` in cycle 3. With `inst_ready` high, `pc_advance` pulses in cycle 3, giving a throughput of one instruction per 4 cycles.
- Each stall cycle of `arready`, `rvalid` or `inst_ready` adds exactly one cycle.
- `pc_advance` is combinational from state and `inst_ready`. The PC register updates on the same edge that returns the IFU to IDLE, so the next `pc` is valid in IDLE.
- At most one outstanding read at any time.

## Structure
- Put the state encodings (IDLE=0, REQ=1, WAIT=2, HOLD=3) and the `RESP_OKAY=2'b00` constant in the shared core defines package `ysyx_25030085_defs`. The LSU read path reuses them.
- Single module; no sub-module is warranted. The timeout counter is inline.

## Test plan
- **Basic fetch:** reset, `pc=32'h8000_0000`, `fetch_en=1`, zero-wait memory returning `32'h0010_0093` → `inst_valid` in cycle 3 with `inst=32'h0010_0093`, `inst_pc=32'h8000_0000`, `fetch_err=0`, and a single `pc_advance` pulse.
- **Stalls:** `arready` low for 2 cycles and `rvalid` delayed 3 cycles → `araddr` stable throughout, `inst_valid` in cycle 8, correct data.
- **Errors:**
  - `pc=32'h8000_0002` → no `arvalid`; HOLD with `inst=32'h0000_0013`, `fetch_err=1`.
  - `rresp=2'b10` → `fetch_err=1`.
- **Flush in WAIT:** `flush` asserted while in WAIT, `rvalid` 2 cycles later → response consumed, `inst_valid` never asserted, back to IDLE.
- **Flush vs accept:** `flush` and `inst_ready` both high in HOLD → `pc_advance=0`, IDLE next cycle.
- **Timeout and reset:**
  - `rvalid` never arrives → `fetch_err=1`, `inst=NOP_INST` after 255 WAIT cycles.
  - `rst` pulsed mid-WAIT → all outputs 0 on the next edge.

Source files
------------

// File: rtl/ysyx_25030085_defs.sv
// Shared core definitions: handshake FSM encodings, bus response codes and
// the fetch result payload used by the IFU and the LSU read path.
package ysyx_25030085_defs;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } xfer_state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            err;
  } fetch_pkt_t;

endpackage

// File: rtl/ysyx_25030085_ifu.sv
// Instruction fetch unit: one AXI4-Lite-style read per instruction, holds the
// word until decode accepts it, and tells the PC register when to step.
module ysyx_25030085_ifu
  import ysyx_25030085_defs::*;
#(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        fetch_en,
  input  logic        flush,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        fetch_err,
  output logic        pc_advance
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  xfer_state_e      state, state_n;
  logic             drop, drop_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      addr_q, addr_n;
  fetch_pkt_t       pkt, pkt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      drop   <= 1'b0;
      cnt    <= '0;
      addr_q <= '0;
      pkt    <= '0;
    end else begin
      state  <= state_n;
      drop   <= drop_n;
      cnt    <= cnt_n;
      addr_q <= addr_n;
      pkt    <= pkt_n;
    end
  end

  always_comb begin
    state_n = state;
    drop_n  = drop;
    cnt_n   = cnt;
    addr_n  = addr_q;
    pkt_n   = pkt;
    unique case (state)
      IDLE: begin
        // An abandoned beat must drain before a new read may be issued.
        if (drop && rvalid) drop_n = 1'b0;
        if (fetch_en && !drop) begin
          addr_n   = pc;
          pkt_n.pc = pc;
          if (pc[1:0] == 2'b00) begin
            state_n = REQ;
          end else begin
            pkt_n.inst = NOP_INST;
            pkt_n.err  = 1'b1;
            state_n    = HOLD;
          end
        end
      end
      REQ: begin
        if (flush) drop_n = 1'b1;
        if (arready) begin
          state_n = WAIT;
          cnt_n   = '0;
        end
      end
      WAIT: begin
        if (rvalid) begin
          if (drop || flush) begin
            drop_n  = 1'b0;
            state_n = IDLE;
          end else begin
            pkt_n.inst = rdata;
            pkt_n.err  = (rresp != RESP_OKAY);
            state_n    = HOLD;
          end
        end else begin
          if (flush) drop_n = 1'b1;
          cnt_n = cnt + CNT_W'(1);
          // Timeout leaves the beat outstanding; the drop flag absorbs it later.
          if (cnt == CNT_LAST) begin
            drop_n = 1'b1;
            if (drop || flush) begin
              state_n = IDLE;
            end else begin
              pkt_n.inst = NOP_INST;
              pkt_n.err  = 1'b1;
              state_n    = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (drop && rvalid) drop_n = 1'b0;
        if (flush || inst_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign araddr     = addr_q;
  assign arvalid    = (state == REQ);
  assign rready     = (state == WAIT) || (drop && (state == IDLE || state == HOLD));
  assign inst       = pkt.inst;
  assign inst_pc    = pkt.pc;
  assign fetch_err  = pkt.err;
  assign inst_valid = (state == HOLD) && !flush;
  assign pc_advance = inst_valid && inst_ready;

endmodule

// File: tb/tb_ysyx_25030085_ifu.sv
// Directed bench for the IFU: stimulus pushes expected fetch results into a
// queue; a negedge monitor pops and compares whenever inst_valid rises.
module tb_ysyx_25030085_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        fetch_en, flush;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [31:0] inst, inst_pc;
  logic        inst_valid, inst_ready, fetch_err, pc_advance;

  ysyx_25030085_ifu dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en), .flush(flush),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .fetch_err(fetch_err), .pc_advance(pc_advance)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   adv_count = 0;
  bit   seen = 1'b0;

  // Memory model configuration and state
  int          ar_delay = 0, r_delay = 0;
  bit          mem_never = 1'b0;
  logic [31:0] mem_data = '0;
  logic [1:0]  mem_resp = 2'b00;
  int          ar_wait, r_wait;
  bit          pending;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rst) begin
      ar_wait <= 0;
      r_wait  <= 0;
      pending <= 1'b0;
    end else begin
      if (arvalid && arready) begin
        pending <= 1'b1;
        r_wait  <= 0;
        ar_wait <= 0;
      end else if (arvalid) begin
        ar_wait <= ar_wait + 1;
      end
      if (pending && !(rvalid && rready)) r_wait <= r_wait + 1;
      if (rvalid && rready) pending <= 1'b0;
    end
  end

  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      arready = arvalid && (ar_wait >= ar_delay);
      rvalid  = pending && !mem_never && (r_wait >= r_delay);
      rdata   = rvalid ? mem_data : 32'h0;
      rresp   = rvalid ? mem_resp : 2'b00;
    end
  end

  // Monitor: compare on first presentation of each instruction
  always @(negedge clk) begin
    if (!rst) begin
      chk("pc_advance_eq", {31'b0, pc_advance}, {31'b0, inst_valid && inst_ready});
      if (pc_advance) adv_count++;
      if (inst_valid && !seen) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_inst: got inst %h pc %h, required no inst_valid (cycle %0d)",
                   inst, inst_pc, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("inst", inst, e.inst);
          chk("inst_pc", inst_pc, e.pc);
          chk("fetch_err", {31'b0, fetch_err}, {31'b0, e.err});
          chk("valid_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      seen = inst_valid;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_fetch(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r,
                             input bit push, input logic [31:0] e_inst, input bit e_err,
                             input int lat);
    exp_t e;
    mem_data = d;
    mem_resp = r;
    pc       = a;
    fetch_en = 1'b1;
    if (push) begin
      e.inst = e_inst; e.pc = a; e.err = e_err; e.cyc = cyc + lat;
      exp_q.push_back(e);
    end
    tick();
    fetch_en = 1'b0;
  endtask

  initial begin
    int adv0;
    rst = 1'b1; pc = '0; fetch_en = 1'b0; flush = 1'b0; inst_ready = 1'b0;
    tick(2);
    @(negedge clk);
    chk("rst_arvalid", {31'b0, arvalid}, 32'h0);
    chk("rst_rready", {31'b0, rready}, 32'h0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_fetch_err", {31'b0, fetch_err}, 32'h0);
    chk("rst_pc_advance", {31'b0, pc_advance}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_araddr", araddr, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Basic zero-wait fetch
    inst_ready = 1'b1;
    adv0 = adv_count;
    start_fetch(32'h8000_0000, 32'h0010_0093, 2'b00, 1'b1, 32'h0010_0093, 1'b0, 3);
    tick(5);
    chk("basic_adv_pulses", 32'(adv_count - adv0), 32'd1);

    // arready stalled 2 cycles, rvalid 3 cycles late
    ar_delay = 2; r_delay = 3;
    start_fetch(32'h8000_0004, 32'h00a0_0113, 2'b00, 1'b1, 32'h00a0_0113, 1'b0, 8);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (arvalid) chk("araddr_stable", araddr, 32'h8000_0004);
      tick();
    end
    ar_delay = 0; r_delay = 0;
    tick(2);

    // Misaligned PC: no bus request, NOP with error
    start_fetch(32'h8000_0002, 32'hffff_ffff, 2'b00, 1'b1, 32'h0000_0013, 1'b1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("misalign_no_arvalid", {31'b0, arvalid}, 32'h0);
      tick();
    end

    // Error response
    start_fetch(32'h8000_0008, 32'hdead_beef, 2'b10, 1'b1, 32'hdead_beef, 1'b1, 3);
    tick(5);
    mem_resp = 2'b00;

    // Flush in WAIT: response drained, nothing presented
    r_delay = 3;
    start_fetch(32'h8000_000c, 32'h1234_5678, 2'b00, 1'b0, 32'h0, 1'b0, 0);
    tick();
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_wait_rready", {31'b0, rready}, 32'h1);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_drop_rready", {31'b0, rready}, 32'h1);
    tick(2);
    @(negedge clk);
    chk("flush_consumed", {31'b0, pending}, 32'h0);
    chk("flush_idle_rready", {31'b0, rready}, 32'h0);
    chk("flush_idle_arvalid", {31'b0, arvalid}, 32'h0);
    r_delay = 0;
    tick(2);

    // Flush and inst_ready together in HOLD
    inst_ready = 1'b0;
    start_fetch(32'h8000_0010, 32'h0030_0193, 2'b00, 1'b1, 32'h0030_0193, 1'b0, 3);
    tick(3);
    flush = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    chk("flushhold_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("flushhold_pc_advance", {31'b0, pc_advance}, 32'h0);
    tick();
    flush = 1'b0; inst_ready = 1'b0;
    @(negedge clk);
    chk("flushhold_idle_valid", {31'b0, inst_valid}, 32'h0);
    chk("flushhold_idle_arvalid", {31'b0, arvalid}, 32'h0);
    tick(2);

    // Timeout: 255 WAIT cycles, then NOP with error, late beat absorbed
    inst_ready = 1'b1;
    mem_never  = 1'b1;
    start_fetch(32'h8000_0014, 32'h0040_0213, 2'b00, 1'b1, 32'h0000_0013, 1'b1, 257);
    tick(257);
    @(negedge clk);
    chk("timeout_absorb_rready", {31'b0, rready}, 32'h1);
    mem_never = 1'b0;
    tick(4);
    @(negedge clk);
    chk("timeout_absorbed", {31'b0, pending}, 32'h0);
    chk("timeout_rready_clear", {31'b0, rready}, 32'h0);

    // Reset in the middle of WAIT
    mem_never = 1'b1;
    start_fetch(32'h8000_0018, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 0);
    tick(2);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_arvalid", {31'b0, arvalid}, 32'h0);
    chk("midrst_rready", {31'b0, rready}, 32'h0);
    chk("midrst_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("midrst_fetch_err", {31'b0, fetch_err}, 32'h0);
    chk("midrst_pc_advance", {31'b0, pc_advance}, 32'h0);
    chk("midrst_inst", inst, 32'h0);
    chk("midrst_inst_pc", inst_pc, 32'h0);
    chk("midrst_araddr", araddr, 32'h0);
    tick();
    rst = 1'b0;
    mem_never = 1'b0;
    tick();

    // Normal fetch after reset
    start_fetch(32'h8000_0100, 32'h0050_0293, 2'b00, 1'b1, 32'h0050_0293, 1'b0, 3);
    tick(6);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
